program_loader: RTL and testbench

//  Writes a program image into the Nibbler's 4096x8 program memory, which the CPU's fetch path reads.

---
 rtl/nibbler_pkg.sv | 22 ++
 rtl/program_loader.sv | 136 +++++++++++++
 tb/tb_program_loader.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/nibbler_pkg.sv
// Shared types and sizes for the Nibbler program-memory loader.
package nibbler_pkg;

    localparam int PROG_ADDR_W = 12;
    localparam int PROG_DATA_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        LEN_HI,
        LEN_LO,
        DATA,
        CSUM,
        DONE,
        ERROR
    } loader_state_t;

    // True in the states that consume stream bytes; the CPU is held in reset there.
    function automatic logic is_loading(input loader_state_t s);
        return (s == LEN_HI) || (s == LEN_LO) || (s == DATA) || (s == CSUM);
    endfunction

endpackage

// File: rtl/program_loader.sv
// Streams a length-prefixed, checksummed image into the Nibbler program memory
// and keeps the CPU in reset until a complete image has verified.
module program_loader
    import nibbler_pkg::*;
#(
    parameter int ADDR_W = PROG_ADDR_W,
    parameter int DATA_W = PROG_DATA_W
) (
    input  logic              clk,
    input  logic              notReset,
    input  logic              start,
    input  logic [DATA_W-1:0] inData,
    input  logic              inValid,
    output logic              inReady,
    output logic [ADDR_W-1:0] memAddr,
    output logic [DATA_W-1:0] memData,
    output logic              notMemWe,
    output logic              cpuNotReset,
    output logic              busy,
    output logic              done,
    output logic              error
);

    loader_state_t     state_q, state_d;
    logic [ADDR_W-1:0] count_q, count_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] sum_q, sum_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_data_q, mem_data_d;
    logic              mem_we_n_q, mem_we_n_d;
    logic              cpu_not_reset_q, cpu_not_reset_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              error_q, error_d;

    logic              xfer;
    logic [DATA_W-1:0] csum_total;

    assign inReady    = is_loading(state_q);
    assign xfer       = inValid & inReady;
    assign csum_total = sum_q + inData;

    always_comb begin
        // NOTE: every _d gets a default first so no path through the case infers a latch.
        state_d    = state_q;
        count_d    = count_q;
        addr_d     = addr_q;
        sum_d      = sum_q;
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;
        mem_we_n_d = 1'b1;

        case (state_q)
            IDLE, DONE, ERROR: begin
                if (start) state_d = LEN_HI;
            end
            LEN_HI: begin
                if (xfer) begin
                    if (inData[DATA_W-1:ADDR_W-DATA_W] != '0) begin
                        state_d = ERROR;
                    end else begin
                        count_d[ADDR_W-1:DATA_W] = inData[ADDR_W-DATA_W-1:0];
                        state_d = LEN_LO;
                    end
                end
            end
            LEN_LO: begin
                if (xfer) begin
                    count_d[DATA_W-1:0] = inData;
                    addr_d  = '0;
                    sum_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (xfer) begin
                    mem_addr_d = addr_q;
                    mem_data_d = inData;
                    mem_we_n_d = 1'b0;
                    sum_d      = sum_q + inData;
                    // The last byte leaves addr at the top of the image instead of wrapping.
                    if (addr_q == count_q) state_d = CSUM;
                    else                   addr_d  = addr_q + 1'b1;
                end
            end
            CSUM: begin
                if (xfer) state_d = (csum_total == '0) ? DONE : ERROR;
            end
            default: state_d = IDLE;
        endcase
    end

    // Status outputs follow the next state so they change on the same edge as the FSM.
    assign cpu_not_reset_d = (state_d == IDLE) || (state_d == DONE);
    assign busy_d          = is_loading(state_d);
    assign done_d          = (state_d == DONE);
    assign error_d         = (state_d == ERROR);

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge notReset) begin
        if (!notReset) begin
            state_q         <= IDLE;
            count_q         <= '0;
            addr_q          <= '0;
            sum_q           <= '0;
            mem_addr_q      <= '0;
            mem_data_q      <= '0;
            mem_we_n_q      <= 1'b1;
            cpu_not_reset_q <= 1'b0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            error_q         <= 1'b0;
        end else begin
            state_q         <= state_d;
            count_q         <= count_d;
            addr_q          <= addr_d;
            sum_q           <= sum_d;
            mem_addr_q      <= mem_addr_d;
            mem_data_q      <= mem_data_d;
            mem_we_n_q      <= mem_we_n_d;
            cpu_not_reset_q <= cpu_not_reset_d;
            busy_q          <= busy_d;
            done_q          <= done_d;
            error_q         <= error_d;
        end
    end

    assign memAddr     = mem_addr_q;
    assign memData     = mem_data_q;
    assign notMemWe    = mem_we_n_q;
    assign cpuNotReset = cpu_not_reset_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign error       = error_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: a behavioural program memory records every
// strobed write and the sequences below compare it against hand-computed images.
module tb_program_loader;

    logic        clk = 1'b0;
    logic        notReset;
    logic        start;
    logic [7:0]  inData;
    logic        inValid;
    logic        inReady;
    logic [11:0] memAddr;
    logic [7:0]  memData;
    logic        notMemWe;
    logic        cpuNotReset;
    logic        busy;
    logic        done;
    logic        error;

    program_loader dut (
        .clk        (clk),
        .notReset   (notReset),
        .start      (start),
        .inData     (inData),
        .inValid    (inValid),
        .inReady    (inReady),
        .memAddr    (memAddr),
        .memData    (memData),
        .notMemWe   (notMemWe),
        .cpuNotReset(cpuNotReset),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    // Program memory model plus write statistics.
    logic [7:0]  mem [4096];
    int          total_wr = 0;
    logic [11:0] last_wr_addr = '0;
    int          run = 0;
    int          last_run = 0;

    always @(posedge clk) begin
        if (notReset && !notMemWe) begin
            mem[memAddr] <= memData;
            total_wr     <= total_wr + 1;
            last_wr_addr <= memAddr;
            run          <= run + 1;
        end else begin
            if (run != 0) last_run <= run;
            run <= 0;
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    logic [7:0] pat [4096];

    // Present one byte (after an optional idle gap) and return just after its transfer edge.
    task automatic send_byte(input logic [7:0] b, input int gap, input logic with_start);
        int budget;
        inValid = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        inData  = b;
        inValid = 1'b1;
        start   = with_start;
        budget  = 0;
        while (!inReady && budget < 50) begin
            @(posedge clk);
            #1;
            budget++;
        end
        if (!inReady) begin
            check("ready_timeout", 32'd0, 32'd1);
            inValid = 1'b0;
            start   = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        if (with_start) check("start_ignored_busy", busy, 1'b1);
    endtask

    task automatic send_image(input logic [7:0] hi, input logic [7:0] lo, input int n,
                              input logic [7:0] csum, input int max_gap, input logic mid_start);
        send_byte(hi, 0, 1'b0);
        send_byte(lo, (max_gap > 0) ? $urandom_range(max_gap, 0) : 0, 1'b0);
        for (int i = 0; i < n; i++)
            send_byte(pat[i], (max_gap > 0) ? $urandom_range(max_gap, 0) : 0,
                      mid_start && (i % 2 == 0));
        send_byte(csum, (max_gap > 0) ? $urandom_range(max_gap, 0) : 0, 1'b0);
        inValid = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic load_abc();
        pat[0] = 8'hA1;
        pat[1] = 8'hB2;
        pat[2] = 8'hC3;
    endtask

    int base;

    initial begin
        notReset = 1'b0;
        start    = 1'b0;
        inValid  = 1'b0;
        inData   = '0;
        repeat (2) @(negedge clk);

        // Reset values
        check("rst_busy",     busy,        1'b0);
        check("rst_done",     done,        1'b0);
        check("rst_error",    error,       1'b0);
        check("rst_inready",  inReady,     1'b0);
        check("rst_memwe_n",  notMemWe,    1'b1);
        check("rst_cpu_nrst", cpuNotReset, 1'b0);
        check("rst_memaddr",  memAddr,     12'h000);
        check("rst_memdata",  memData,     8'h00);
        notReset = 1'b1;
        @(negedge clk);
        check("idle_cpu_nrst", cpuNotReset, 1'b1);

        // Test 1: A1,B2,C3; 0xA1+0xB2+0xC3 = 0x216, so the balancing checksum is 0xEA
        load_abc();
        base = total_wr;
        pulse_start();
        check("t1_busy",     busy,        1'b1);
        check("t1_cpu_held", cpuNotReset, 1'b0);
        check("t1_inready",  inReady,     1'b1);
        send_image(8'h00, 8'h02, 3, 8'hEA, 0, 1'b0);
        repeat (2) @(negedge clk);
        check("t1_writes",   total_wr - base, 3);
        check("t1_mem0",     mem[0], 8'hA1);
        check("t1_mem1",     mem[1], 8'hB2);
        check("t1_mem2",     mem[2], 8'hC3);
        check("t1_strobe_run", last_run, 3);
        check("t1_done",     done,        1'b1);
        check("t1_error",    error,       1'b0);
        check("t1_busy_end", busy,        1'b0);
        check("t1_cpu_run",  cpuNotReset, 1'b1);

        // Test 2: same image, checksum 0x00 is wrong
        base = total_wr;
        pulse_start();
        check("t2_done_cleared", done, 1'b0);
        send_image(8'h00, 8'h02, 3, 8'h00, 0, 1'b0);
        repeat (2) @(negedge clk);
        check("t2_writes",   total_wr - base, 3);
        check("t2_error",    error,       1'b1);
        check("t2_done",     done,        1'b0);
        check("t2_cpu_held", cpuNotReset, 1'b0);
        pulse_start();
        check("t2_error_cleared", error, 1'b0);
        send_image(8'h00, 8'h02, 3, 8'hEA, 0, 1'b0);
        repeat (2) @(negedge clk);
        check("t2_retry_done", done, 1'b1);
        check("t2_retry_cpu",  cpuNotReset, 1'b1);

        // Test 3: bad header high nibble
        base = total_wr;
        pulse_start();
        send_byte(8'h10, 0, 1'b0);
        inValid = 1'b0;
        repeat (2) @(negedge clk);
        check("t3_error",    error,       1'b1);
        check("t3_writes",   total_wr - base, 0);
        check("t3_cpu_held", cpuNotReset, 1'b0);
        check("t3_inready",  inReady,     1'b0);

        // Test 4: full 4096-byte image of 0x01, sum = 4096 mod 256 = 0
        for (int i = 0; i < 4096; i++) pat[i] = 8'h01;
        base = total_wr;
        pulse_start();
        send_image(8'h0F, 8'hFF, 4096, 8'h00, 0, 1'b0);
        repeat (2) @(negedge clk);
        check("t4_writes",    total_wr - base, 4096);
        check("t4_last_addr", last_wr_addr, 12'hFFF);
        check("t4_memaddr",   memAddr,      12'hFFF);
        check("t4_mem_top",   mem[4095],    8'h01);
        check("t4_mem_bottom", mem[0],      8'h01);
        check("t4_done",      done,         1'b1);

        // Test 5: random gaps and start pulses while busy
        load_abc();
        base = total_wr;
        pulse_start();
        send_image(8'h00, 8'h02, 3, 8'hEA, 3, 1'b1);
        repeat (2) @(negedge clk);
        check("t5_writes", total_wr - base, 3);
        check("t5_mem0",   mem[0], 8'hA1);
        check("t5_mem1",   mem[1], 8'hB2);
        check("t5_mem2",   mem[2], 8'hC3);
        check("t5_mem3",   mem[3], 8'h01);
        check("t5_done",   done,   1'b1);

        // Test 6: reset asserted with the 2nd data byte's strobe still pending
        base = total_wr;
        pulse_start();
        send_byte(8'h00, 0, 1'b0);
        send_byte(8'h02, 0, 1'b0);
        send_byte(8'h5A, 0, 1'b0);
        send_byte(8'h6B, 0, 1'b0);
        inValid = 1'b0;
        check("t6_strobe_pending", notMemWe, 1'b0);
        @(negedge clk);
        notReset = 1'b0;
        #1;
        check("t6_rst_memwe_n", notMemWe,    1'b1);
        check("t6_rst_cpu",     cpuNotReset, 1'b0);
        check("t6_rst_busy",    busy,        1'b0);
        check("t6_rst_inready", inReady,     1'b0);
        repeat (2) @(negedge clk);
        check("t6_rst_cpu_hold", cpuNotReset, 1'b0);
        notReset = 1'b1;
        #1;
        check("t6_release_cpu", cpuNotReset, 1'b0);
        @(negedge clk);
        check("t6_after_cpu",   cpuNotReset, 1'b1);
        check("t6_after_busy",  busy,        1'b0);
        check("t6_writes",      total_wr - base, 1);
        check("t6_mem0",        mem[0],      8'h5A);
        check("t6_mem1",        mem[1],      8'hB2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
